// File: rtl/scpu_pkg.sv
// Shared constants and state encoding for the multi-cycle scalar core.
// Optional flags output is enabled with SCPU_FLAGS_EN.
package scpu_pkg;

    localparam logic [1:0] CLS_NOP   = 2'b00;
    localparam logic [1:0] CLS_ALU   = 2'b01;
    localparam logic [1:0] CLS_LOAD  = 2'b10;
    localparam logic [1:0] CLS_STORE = 2'b11;

    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;
    localparam logic [3:0] FN_AND = 4'd2;
    localparam logic [3:0] FN_OR  = 4'd3;
    localparam logic [3:0] FN_XOR = 4'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

endpackage

// File: rtl/scpu_alu.sv
// Combinational ALU: add/sub with carry/borrow, logic ops, reserved funct flag.
module scpu_alu
    import scpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [3:0]            funct,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  carry,
    output logic                  illegal
);

    logic [DATA_WIDTH:0] sum;
    logic [DATA_WIDTH:0] dif;

    // Top bit of the widened difference is the borrow (a < b)
    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} - {1'b0, b};

    always_comb begin
        y       = '0;
        carry   = 1'b0;
        illegal = 1'b0;
        case (funct)
            FN_ADD:  {carry, y} = sum;
            FN_SUB:  {carry, y} = dif;
            FN_AND:  y = a & b;
            FN_OR:   y = a | b;
            FN_XOR:  y = a ^ b;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/scpu_multicycle.sv
// Multi-cycle core: handshake-fed DECODE/EXEC/MEM/WB with internal regfile and memory.
// Define SCPU_FLAGS_EN to add the flag_z/flag_c outputs.
module scpu_multicycle
    import scpu_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_BITS   = 5,
    parameter int REG_BITS    = 2,
    parameter int INSTR_WIDTH = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   illegal,
`ifdef SCPU_FLAGS_EN
    output logic                   flag_z,
    output logic                   flag_c,
`endif
    input  logic [REG_BITS-1:0]    dbg_raddr,
    output logic [DATA_WIDTH-1:0]  dbg_rdata
);

    localparam int NREG  = 2 ** REG_BITS;
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam int IW    = INSTR_WIDTH;

    if (INSTR_WIDTH != 2 + 3 * REG_BITS + DATA_WIDTH + 4) begin : g_bad_width
        $fatal(1, "scpu_multicycle: INSTR_WIDTH inconsistent with field widths");
    end

    state_t state, nxt;

    logic [IW-1:0]         ir;
    logic [DATA_WIDTH-1:0] rf  [NREG];
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] opa, opb, opd, res, ldata;
    logic [ADDR_BITS-1:0]  addr;
    logic                  ill;

    logic [1:0]            cls;
    logic [REG_BITS-1:0]   x1, x2, x3;
    logic [DATA_WIDTH-1:0] imm;
    logic [3:0]            fn;

    logic [DATA_WIDTH-1:0] alu_y;
    logic                  alu_ill;

    assign cls = ir[IW-1 -: 2];
    assign x1  = ir[IW-3 -: REG_BITS];
    assign x2  = ir[IW-3-REG_BITS -: REG_BITS];
    assign x3  = ir[IW-3-2*REG_BITS -: REG_BITS];
    assign imm = ir[4 +: DATA_WIDTH];
    assign fn  = ir[3:0];

    assign instr_ready = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_WB);
    assign illegal     = done & ill;
    assign dbg_rdata   = rf[dbg_raddr];

`ifdef SCPU_FLAGS_EN
    logic alu_c, res_c;

    scpu_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .a(opa), .b(opb), .funct(fn),
        .y(alu_y), .carry(alu_c), .illegal(alu_ill)
    );
`else
    scpu_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .a(opa), .b(opb), .funct(fn),
        .y(alu_y), .carry(), .illegal(alu_ill)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:   if (instr_valid) nxt = S_DECODE;
            S_DECODE: nxt = S_EXEC;
            S_EXEC:   nxt = cls[1] ? S_MEM : S_WB;
            S_MEM:    nxt = S_WB;
            S_WB:     nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir    <= '0;
            opa   <= '0;
            opb   <= '0;
            opd   <= '0;
            res   <= '0;
            ldata <= '0;
            addr  <= '0;
            ill   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (instr_valid) ir <= instr;
                S_DECODE: begin
                    opa <= rf[x2];
                    opb <= rf[x3];
                    opd <= rf[x1];
                end
                S_EXEC: begin
                    res  <= alu_y;
                    ill  <= (cls == CLS_ALU) & alu_ill;
                    addr <= ADDR_BITS'(opa + imm);
                end
                S_MEM: if (cls == CLS_LOAD) ldata <= mem[addr];
                default: ;
            endcase
        end
    end

    // Register file comes out of reset holding its own indices
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= DATA_WIDTH'(i);
        end else if (state == S_WB) begin
            if (cls == CLS_ALU && !ill) rf[x1] <= res;
            else if (cls == CLS_LOAD)   rf[x1] <= ldata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == S_MEM && cls == CLS_STORE) begin
            mem[addr] <= opd;
        end
    end

`ifdef SCPU_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_c  <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            if (state == S_EXEC) res_c <= alu_c;
            if (state == S_WB && cls == CLS_ALU && !ill) begin
                flag_z <= (res == '0);
                flag_c <= res_c;
            end
        end
    end
`endif

endmodule

// File: tb/tb_scpu_multicycle.sv
// Randomized and directed bench for scpu_multicycle against a behavioural model.
// Flag checks are active when SCPU_FLAGS_EN is defined.
module tb_scpu_multicycle;

    localparam int DW = 8;
    localparam int RB = 2;
    localparam int IW = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready, busy, done, illegal;
    logic [RB-1:0] dbg_raddr;
    logic [DW-1:0] dbg_rdata;
`ifdef SCPU_FLAGS_EN
    logic          flag_z, flag_c;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] mrf  [4];
    logic [7:0] mmem [32];
    logic       mz, mc;
    bit         rand_dbg = 0;
    bit         run = 0;

    always #5 clk = ~clk;

    scpu_multicycle dut (
        .clk(clk),
        .rst(rst),
        .instr(instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .busy(busy),
        .done(done),
        .illegal(illegal),
`ifdef SCPU_FLAGS_EN
        .flag_z(flag_z),
        .flag_c(flag_c),
`endif
        .dbg_raddr(dbg_raddr),
        .dbg_rdata(dbg_rdata)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk(int c, int a1, int a2, int a3, int im, int f);
        return {2'(c), 2'(a1), 2'(a2), 2'(a3), 8'(im), 4'(f)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mrf[i] = 8'(i);
        for (int i = 0; i < 32; i++) mmem[i] = 8'h00;
        mz = 1'b0;
        mc = 1'b0;
    endtask

    // Checks visible state against the model on every cycle out of reset
    always @(negedge clk) begin
        if (run && !rst) begin
            chk("dbg_rdata", int'(dbg_rdata), int'(mrf[dbg_raddr]));
            chk("ready_vs_busy", int'(instr_ready), int'(!busy));
            if (illegal) chk("illegal_without_done", int'(done), 1);
`ifdef SCPU_FLAGS_EN
            chk("flag_z", int'(flag_z), int'(mz));
            chk("flag_c", int'(flag_c), int'(mc));
`endif
            if (rand_dbg) dbg_raddr = RB'($urandom_range(0, 3));
        end
    end

    task automatic issue(input logic [IW-1:0] w, input bit pulse);
        int c, a1, a2, a3, im, f, a, b, r, lat, n, adr;
        bit ill, got;
        c   = int'(w[19:18]);
        a1  = int'(w[17:16]);
        a2  = int'(w[15:14]);
        a3  = int'(w[13:12]);
        im  = int'(w[11:4]);
        f   = int'(w[3:0]);
        ill = (c == 1) && (f > 4);
        lat = (c >= 2) ? 4 : 3;
        @(negedge clk);
        chk("idle_before_issue", int'(instr_ready && !busy && !done), 1);
        instr = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        if (pulse) instr = IW'($urandom);
        else instr_valid = 1'b0;
        n = 0;
        got = 0;
        while (!got && n < 8) begin
            @(negedge clk);
            n++;
            if (n == 2) instr_valid = 1'b0;
            if (done) got = 1;
        end
        chk("latency", got ? n : -1, lat);
        chk("illegal", int'(illegal), int'(ill));
        @(posedge clk);
        a = int'(mrf[a2]);
        b = int'(mrf[a3]);
        adr = (a + im) % 32;
        if (c == 1 && !ill) begin
            case (f)
                0: begin r = a + b; mc = (r > 255); end
                1: begin r = a - b; mc = (a < b);   end
                2: begin r = a & b; mc = 1'b0;      end
                3: begin r = a | b; mc = 1'b0;      end
                default: begin r = a ^ b; mc = 1'b0; end
            endcase
            mrf[a1] = 8'(r);
            mz = (8'(r) == 8'h00);
        end else if (c == 2) begin
            mrf[a1] = mmem[adr];
        end else if (c == 3) begin
            mmem[adr] = mrf[a1];
        end
    endtask

    task automatic chk_reg(input int idx, input int exp);
        rand_dbg = 0;
        @(posedge clk);
        dbg_raddr = RB'(idx);
        @(negedge clk);
        chk($sformatf("reg%0d", idx), int'(dbg_rdata), exp);
    endtask

    initial begin
        rst = 1'b1;
        instr = '0;
        instr_valid = 1'b0;
        dbg_raddr = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_ready", int'(instr_ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done | illegal), 0);
        rst = 1'b0;
        run = 1;
        for (int i = 0; i < 4; i++) chk_reg(i, i);

        issue(20'b01000111000000000000, 0);
        chk_reg(0, 4);
        issue(mk(1, 1, 0, 3, 0, 0), 0);
        chk_reg(1, 7);
        issue(mk(1, 3, 0, 2, 0, 1), 0);
        chk_reg(3, 2);
        issue(mk(1, 0, 0, 3, 0, 2), 0);
        chk_reg(0, 0);
        issue(mk(1, 0, 0, 2, 0, 1), 0);
        chk_reg(0, 8'hFE);
        issue(mk(3, 1, 2, 0, 15, 0), 0);
        issue(mk(2, 3, 2, 0, 15, 0), 0);
        chk_reg(3, 7);
        issue(mk(1, 3, 1, 1, 0, 0), 0);
        issue(mk(1, 3, 3, 2, 0, 0), 0);
        issue(mk(1, 3, 3, 2, 0, 0), 0);
        issue(mk(1, 3, 3, 2, 0, 0), 0);
        chk_reg(3, 20);
        issue(mk(3, 1, 2, 0, 1, 0), 0);
        issue(mk(2, 0, 3, 0, 15, 0), 0);
        chk_reg(0, 7);
        issue(mk(1, 1, 2, 3, 0, 9), 1);
        chk_reg(1, 7);
        issue(mk(0, 2, 1, 1, 5, 0), 1);
        chk_reg(2, 2);

        // Abort an ADD into r2 while it sits in EXEC
        @(negedge clk);
        instr = mk(1, 2, 0, 1, 0, 0);
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        chk("abort_ready", int'(instr_ready), 1);
        chk("abort_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) chk_reg(i, i);

        issue(mk(1, 2, 0, 1, 0, 1), 0);
        chk_reg(2, 8'hFF);
        issue(mk(1, 3, 2, 1, 0, 0), 0);
        chk_reg(3, 0);
`ifdef SCPU_FLAGS_EN
        chk("flag_z_ff_plus_1", int'(flag_z), 1);
        chk("flag_c_ff_plus_1", int'(flag_c), 1);
`endif

        rand_dbg = 1;
        for (int k = 0; k < 120; k++) begin
            issue(mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 6)),
                  bit'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 4; i++) chk_reg(i, int'(mrf[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
